vedic_mul_seq: RTL

//  Parametrised, sequential unsigned multiplier; successor to the fixed-width

---
 rtl/vedic_mul_seq_if.sv | 24 ++
 rtl/vedic_mul_seq.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/vedic_mul_seq_if.sv
// Operand/product handshake bundle for vedic_mul_seq.
// Master drives operands and out_ready; slave returns status and product.
interface vedic_mul_seq_if #(
    parameter int WIDTH = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] mul;
    logic               busy;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, mul, busy
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, mul, busy
    );
endinterface

// File: rtl/vedic_mul_seq.sv
// Sequential unsigned multiplier: one HxH Urdhva-Tiryagbhyam core
// reused over four cycles to sum the half-width partial products.
module vedic_mul_seq #(
    parameter int WIDTH = 8
) (
    input logic           clk,
    input logic           rst,
    vedic_mul_seq_if.slave bus
);
    localparam int H = WIDTH / 2;
    localparam int P = 2 * WIDTH;

    if ((WIDTH % 2) != 0 || WIDTH < 2) begin : g_bad_width
        $error("vedic_mul_seq: WIDTH must be even and >= 2");
    end

    typedef enum logic [2:0] {
        IDLE, PP0, PP1, PP2, PP3, DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [P-1:0]     acc_q, acc_d;
    logic [P-1:0]     mul_q, mul_d;
    logic             outv_q, outv_d;

    logic [H-1:0]     x, y;
    logic [WIDTH-1:0] pp;
    logic [P-1:0]     pp_sh;

    // Crosswise column sums; the running carry ripples into higher columns.
    function automatic logic [WIDTH-1:0] ut_mul(
        input logic [H-1:0] xa,
        input logic [H-1:0] yb
    );
        logic [WIDTH-1:0] r;
        int unsigned      s;
        r = '0;
        s = 0;
        for (int k = 0; k < WIDTH; k++) begin
            for (int i = 0; i < H; i++) begin
                if (k - i >= 0 && k - i < H)
                    s = s + 32'(xa[i] & yb[k-i]);
            end
            r[k] = s[0];
            s    = s >> 1;
        end
        return r;
    endfunction

    always_comb begin
        x     = a_q[H-1:0];
        y     = b_q[H-1:0];
        unique case (state_q)
            PP1: x = a_q[WIDTH-1:H];
            PP2: y = b_q[WIDTH-1:H];
            PP3: begin
                x = a_q[WIDTH-1:H];
                y = b_q[WIDTH-1:H];
            end
            default: ;
        endcase
    end

    assign pp = ut_mul(x, y);

    always_comb begin
        pp_sh = {{WIDTH{1'b0}}, pp};
        unique case (state_q)
            PP1, PP2: pp_sh = {{WIDTH{1'b0}}, pp} << H;
            PP3:      pp_sh = {{WIDTH{1'b0}}, pp} << WIDTH;
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        mul_d   = mul_q;
        outv_d  = outv_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    acc_d   = '0;
                    state_d = PP0;
                end
            end
            PP0: begin
                acc_d   = acc_q + pp_sh;
                state_d = PP1;
            end
            PP1: begin
                acc_d   = acc_q + pp_sh;
                state_d = PP2;
            end
            PP2: begin
                acc_d   = acc_q + pp_sh;
                state_d = PP3;
            end
            PP3: begin
                mul_d   = acc_q + pp_sh;
                outv_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    outv_d = 1'b0;
                    if (bus.in_valid) begin
                        a_d     = bus.A;
                        b_d     = bus.B;
                        acc_d   = '0;
                        state_d = PP0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            mul_q   <= '0;
            outv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            mul_q   <= mul_d;
            outv_q  <= outv_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE) ||
                           (state_q == DONE && bus.out_ready);
    assign bus.out_valid = outv_q;
    assign bus.mul       = mul_q;
    assign bus.busy      = (state_q != IDLE);
endmodule
